shift_sequencer: RTL

//  Multi-cycle controller that sequences one shared SHIFT32 barrel shifter to run SLL/SRL/ROL/ROR(/SRA).

---
 rtl/shift_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: sequences one shared 32-bit barrel shifter to perform
// SLL, SRL, ROL and ROR, plus SRA when SHIFT_SEQ_SRA_EN is defined.
// A rotate is built from two passes whose results are OR-merged in acc_q.
// SRA is a logical right shift OR-ed with a sign mask taken from a second pass.
// Y/ERR come from output registers that load only on entry to DONE. They
// therefore stay stable while a result is handed off and afterwards.
//
// state | meaning
// IDLE  | waiting for a request, IN_READY=1
// PASS1 | first shifter pass, acc <= result
// PASS2 | second pass for rotates/SRA, acc <= acc | result
// DONE  | OUT_VALID=1, waiting for OUT_READY
module shift_sequencer #(
  parameter logic [31:0] ILLEGAL_VALUE = 32'h0000_0000,
  parameter bit          ZERO_ROT_SKIP = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [2:0]  OP,
  input  logic [31:0] D,
  input  logic [31:0] S,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] Y,
  output logic        ERR,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_ROL = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
`ifdef SHIFT_SEQ_SRA_EN
  localparam logic [2:0] OP_SRA = 3'b100;
`endif

  state_e      state_q, state_d;
  logic [31:0] d_q, d_d;
  logic [31:0] s_q, s_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] acc_q, acc_d;
  logic        err_q, err_d;
  logic [31:0] y_q, y_d;
  logic        erro_q, erro_d;

  logic        is_rot;
  logic        is_sra;
  logic        legal;
  logic        rot_zero;

  logic [31:0] sh_data;
  logic [31:0] sh_amt;
  logic        sh_lnr;
  logic [31:0] sh_res;

  // Decode of the latched opcode.
  always_comb begin
    is_rot   = (op_q == OP_ROL) || (op_q == OP_ROR);
`ifdef SHIFT_SEQ_SRA_EN
    is_sra   = (op_q == OP_SRA);
`else
    is_sra   = 1'b0;
`endif
    legal    = (op_q == OP_SLL) || (op_q == OP_SRL) || is_rot || is_sra;
    rot_zero = (s_q[4:0] == 5'd0);
  end

  // Shared shifter; any amount of 32 or more shifts everything out.
  always_comb begin
    if (|sh_amt[31:5]) begin
      sh_res = 32'h0000_0000;
    end else if (sh_lnr) begin
      sh_res = sh_data << sh_amt[4:0];
    end else begin
      sh_res = sh_data >> sh_amt[4:0];
    end
  end

  // Next-state, shifter input muxing and datapath updates.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    s_d     = s_q;
    op_d    = op_q;
    acc_d   = acc_q;
    err_d   = err_q;
    y_d     = y_q;
    erro_d  = erro_q;
    sh_data = d_q;
    sh_amt  = s_q;
    sh_lnr  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          d_d     = D;
          s_d     = S;
          op_d    = OP;
          err_d   = 1'b0;
          state_d = ST_PASS1;
        end
      end

      ST_PASS1: begin
        sh_data = d_q;
        case (op_q)
          OP_SLL: begin sh_lnr = 1'b1; sh_amt = s_q; end
          OP_SRL: begin sh_lnr = 1'b0; sh_amt = s_q; end
          OP_ROL: begin sh_lnr = 1'b1; sh_amt = {27'b0, s_q[4:0]}; end
          OP_ROR: begin sh_lnr = 1'b0; sh_amt = {27'b0, s_q[4:0]}; end
          default: begin sh_lnr = 1'b0; sh_amt = s_q; end
        endcase
        if (legal) begin
          acc_d = sh_res;
          err_d = 1'b0;
        end else begin
          acc_d = ILLEGAL_VALUE;
          err_d = 1'b1;
        end
        if (!(is_rot || is_sra)) begin
          state_d = ST_DONE;
        end else if (is_rot && rot_zero && ZERO_ROT_SKIP) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_PASS2;
        end
      end

      ST_PASS2: begin
        if (is_rot) begin
          // Opposite direction by (32 - r); r == 0 gives 32, i.e. nothing added.
          sh_data = d_q;
          sh_lnr  = (op_q == OP_ROR);
          sh_amt  = {26'b0, 6'd32 - {1'b0, s_q[4:0]}};
          acc_d   = acc_q | sh_res;
        end
`ifdef SHIFT_SEQ_SRA_EN
        else if (is_sra) begin
          // Inverted logical shift of all-ones marks the vacated upper bits.
          sh_data = 32'hFFFF_FFFF;
          sh_lnr  = 1'b0;
          sh_amt  = s_q;
          acc_d   = acc_q | (d_q[31] ? ~sh_res : 32'h0000_0000);
        end
`endif
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (OUT_READY) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      y_d    = acc_d;
      erro_d = err_d;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      d_q     <= 32'h0;
      s_q     <= 32'h0;
      op_q    <= 3'b0;
      acc_q   <= 32'h0;
      err_q   <= 1'b0;
      y_q     <= 32'h0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      s_q     <= s_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      y_q     <= y_d;
      erro_q  <= erro_d;
    end
  end

  assign IN_READY  = (state_q == ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE);
  assign OUT_VALID = (state_q == ST_DONE);
  assign Y         = y_q;
  assign ERR       = erro_q;

endmodule
